full_adder: RTL and testbench

- Parameterised COUNT-bit binary adder with carry-in and carry-out, built as a ripple of 1-bit full-adder cells.
- Sum and carry are available combinationally with zero latency for datapath use.
- A registered copy with valid flag serves pipelined consumers.
- Generic arithmetic leaf block inside ALU and counter datapaths.

---
 rtl/full_adder_pkg.sv | 21 ++
 rtl/full_adder_bit.sv | 23 ++
 rtl/full_adder.sv | 80 ++++++++
 tb/tb_full_adder.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/full_adder_pkg.sv
// -----------------------------------------------------------------------------
// full_adder_pkg
//   Shared types for the full_adder block.
//   fa_flags_t : carry-out / signed-overflow flag pair held by the output stage.
//   fa_flags() : builds an fa_flags_t from the two raw flag bits.
// -----------------------------------------------------------------------------
package full_adder_pkg;

    typedef struct packed {
        logic cout;
        logic ovf;
    } fa_flags_t;

    function automatic fa_flags_t fa_flags(input logic cout, input logic ovf);
        fa_flags_t f;
        f.cout = cout;
        f.ovf  = ovf;
        return f;
    endfunction

endpackage

// File: rtl/full_adder_bit.sv
// -----------------------------------------------------------------------------
// full_adder_bit
//   One-bit full-adder cell, purely combinational.
//   a, b : operand bits
//   ci   : carry in
//   s    : sum bit, a ^ b ^ ci
//   co   : carry out, generate | (propagate & ci)
// -----------------------------------------------------------------------------
module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic w_p;

    assign w_p = a ^ b;
    assign s   = w_p ^ ci;
    assign co  = (a & b) | (ci & w_p);

endmodule

// File: rtl/full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
//   COUNT-bit ripple-carry adder built from full_adder_bit cells, with a
//   zero-latency combinational result and a one-cycle registered copy.
//   clk, rst_n          : clock (rising edge), async active-low reset
//   A, B, Cin           : operands and carry-in
//   in_valid            : qualifies A/B/Cin for the registered path
//   S, Cout, Ovf        : combinational sum, carry-out, signed overflow
//   S_r, Cout_r, Ovf_r  : registered S/Cout/Ovf, loaded when in_valid=1
//   out_valid           : in_valid delayed one cycle
// -----------------------------------------------------------------------------
module full_adder
    import full_adder_pkg::*;
#(
    parameter int COUNT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [COUNT-1:0] A,
    input  logic [COUNT-1:0] B,
    input  logic             Cin,
    input  logic             in_valid,
    output logic [COUNT-1:0] S,
    output logic             Cout,
    output logic             Ovf,
    output logic [COUNT-1:0] S_r,
    output logic             Cout_r,
    output logic             Ovf_r,
    output logic             out_valid
);

    // w_c[i] is the carry into bit i; w_c[COUNT] is the carry out.
    logic [COUNT:0]   w_c;
    logic [COUNT-1:0] w_s;

    assign w_c[0] = Cin;

    generate
        for (genvar gi = 0; gi < COUNT; gi++) begin : g_bit
            full_adder_bit u_bit (
                .a  (A[gi]),
                .b  (B[gi]),
                .ci (w_c[gi]),
                .s  (w_s[gi]),
                .co (w_c[gi+1])
            );
        end
    endgenerate

    // Signed overflow: carry into the MSB disagrees with carry out of it.
    // For COUNT=1 the carry into the MSB is Cin itself.
    assign S    = w_s;
    assign Cout = w_c[COUNT];
    assign Ovf  = w_c[COUNT-1] ^ w_c[COUNT];

    // Output stage: result loads only on valid, valid flag loads every cycle.
    logic [COUNT-1:0] r_s;
    fa_flags_t        r_flags;
    logic             r_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s     <= '0;
            r_flags <= '0;
            r_vld   <= 1'b0;
        end else begin
            r_vld <= in_valid;
            if (in_valid) begin
                r_s     <= w_s;
                r_flags <= fa_flags(w_c[COUNT], w_c[COUNT-1] ^ w_c[COUNT]);
            end
        end
    end

    assign S_r       = r_s;
    assign Cout_r    = r_flags.cout;
    assign Ovf_r     = r_flags.ovf;
    assign out_valid = r_vld;

endmodule

// File: tb/tb_full_adder.sv
module tb_full_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    // COUNT=4 instance
    logic [3:0] a4, b4, s4, sr4;
    logic cin4, iv4, cout4, ovf4, coutr4, ovfr4, ov4;
    // COUNT=1 instance
    logic [0:0] a1, b1, s1, sr1;
    logic cin1, iv1, cout1, ovf1, coutr1, ovfr1, ov1;
    // COUNT=8 instance
    logic [7:0] a8, b8, s8, sr8;
    logic cin8, iv8, cout8, ovf8, coutr8, ovfr8, ov8;

    full_adder #(.COUNT(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .A(a4), .B(b4), .Cin(cin4), .in_valid(iv4),
        .S(s4), .Cout(cout4), .Ovf(ovf4), .S_r(sr4), .Cout_r(coutr4),
        .Ovf_r(ovfr4), .out_valid(ov4));
    full_adder #(.COUNT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .A(a1), .B(b1), .Cin(cin1), .in_valid(iv1),
        .S(s1), .Cout(cout1), .Ovf(ovf1), .S_r(sr1), .Cout_r(coutr1),
        .Ovf_r(ovfr1), .out_valid(ov1));
    full_adder #(.COUNT(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .A(a8), .B(b8), .Cin(cin8), .in_valid(iv8),
        .S(s8), .Cout(cout8), .Ovf(ovf8), .S_r(sr8), .Cout_r(coutr8),
        .Ovf_r(ovfr8), .out_valid(ov8));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Independent overflow reference: signed sum leaves the w-bit range.
    function automatic logic ovf_ref(input longint a, input longint b, input longint cin, input int w);
        longint sa, sb, ss, lo, hi;
        sa = (a >= (longint'(1) << (w-1))) ? a - (longint'(1) << w) : a;
        sb = (b >= (longint'(1) << (w-1))) ? b - (longint'(1) << w) : b;
        ss = sa + sb + cin;
        lo = -(longint'(1) << (w-1));
        hi = (longint'(1) << (w-1)) - 1;
        return (ss < lo) || (ss > hi);
    endfunction

    task automatic set4(input logic [3:0] a, input logic [3:0] b, input logic c);
        a4 = a; b4 = b; cin4 = c;
        #1;
    endtask

    initial begin
        longint sum;
        rst_n = 1'b0;
        iv4 = 1'b0; iv1 = 1'b0; iv8 = 1'b0;
        a1 = '0; b1 = '0; cin1 = 1'b0;
        a8 = '0; b8 = '0; cin8 = 1'b0;

        // Reset state, combinational path live during reset
        set4(4'b0000, 4'b0000, 1'b0);
        chk("rst_s_r4", sr4, 0);
        chk("rst_flags4", {coutr4, ovfr4, ov4}, 0);
        chk("rst_r1", {sr1, coutr1, ovfr1, ov1}, 0);
        chk("rst_r8", {sr8, coutr8, ovfr8, ov8}, 0);
        chk("zero_s", s4, 4'b0000);
        chk("zero_co_ovf", {cout4, ovf4}, 2'b00);
        set4(4'b0000, 4'b0001, 1'b0);
        chk("rst_comb_s", s4, 4'b0001);

        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors
        set4(4'b0000, 4'b0001, 1'b0);
        chk("d1_s", s4, 4'b0001); chk("d1_co", cout4, 0);
        set4(4'b0001, 4'b0010, 1'b0);
        chk("d2_s", s4, 4'b0011); chk("d2_co", cout4, 0);
        set4(4'b1111, 4'b0001, 1'b1);
        chk("d3_s", s4, 4'b0001); chk("d3_co", cout4, 1); chk("d3_ovf", ovf4, 0);
        set4(4'b0111, 4'b0001, 1'b0);
        chk("d4_s", s4, 4'b1000); chk("d4_co", cout4, 0); chk("d4_ovf", ovf4, 1);
        set4(4'b1111, 4'b0000, 1'b1);
        chk("wrap1_s", s4, 4'b0000); chk("wrap1_co", cout4, 1);
        set4(4'b1111, 4'b1111, 1'b1);
        chk("wrap2_s", s4, 4'b1111); chk("wrap2_co", cout4, 1); chk("wrap2_ovf", ovf4, 0);
        set4(4'b1000, 4'b1000, 1'b0);
        chk("negovf_s", s4, 4'b0000); chk("negovf_flags", {cout4, ovf4}, 2'b11);

        // Registered path: capture, then hold
        @(negedge clk);
        a4 = 4'b0011; b4 = 4'b0101; cin4 = 1'b1; iv4 = 1'b1;
        @(posedge clk); #1;
        chk("reg_s_r", sr4, 4'b1001);
        chk("reg_cout_r", coutr4, 0);
        chk("reg_ovf_r", ovfr4, 1);
        chk("reg_vld", ov4, 1);
        @(negedge clk);
        iv4 = 1'b0; a4 = 4'b1111; b4 = 4'b1111; cin4 = 1'b0;
        @(posedge clk); #1;
        chk("hold_s_r", sr4, 4'b1001);
        chk("hold_flags", {coutr4, ovfr4}, 2'b01);
        chk("hold_vld", ov4, 0);

        // Load again so out_valid is high, then reset between edges
        @(negedge clk);
        a4 = 4'b0110; b4 = 4'b0011; cin4 = 1'b0; iv4 = 1'b1;
        @(posedge clk); #1;
        chk("pre_rst_s_r", sr4, 4'b1001);
        chk("pre_rst_vld", ov4, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_s_r", sr4, 0);
        chk("async_rst_flags", {coutr4, ovfr4, ov4}, 0);
        set4(4'b0010, 4'b0010, 1'b1);
        chk("rst_track_s", s4, 4'b0101);
        @(posedge clk); #1;
        chk("rst_no_capture", {sr4, coutr4, ovfr4, ov4}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        a4 = 4'b0001; b4 = 4'b0001; cin4 = 1'b0; iv4 = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_s_r", sr4, 4'b0010);
        chk("post_rst_vld", ov4, 1);
        @(negedge clk);
        iv4 = 1'b0;

        // Exhaustive COUNT=4 sweep
        for (int c = 0; c < 2; c++)
            for (int a = 0; a < 16; a++)
                for (int b = 0; b < 16; b++) begin
                    set4(4'(a), 4'(b), 1'(c));
                    sum = longint'(a) + b + c;
                    chk("sweep4_sum", {cout4, s4}, sum);
                    chk("sweep4_ovf", ovf4, ovf_ref(a, b, c, 4));
                end

        // COUNT=1 and COUNT=8 random vectors
        for (int i = 0; i < 40; i++) begin
            a1 = 1'($urandom); b1 = 1'($urandom); cin1 = 1'($urandom);
            a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
            #1;
            sum = longint'(a1) + b1 + cin1;
            chk("rnd1_sum", {cout1, s1}, sum);
            chk("rnd1_ovf", ovf1, ovf_ref(a1, b1, cin1, 1));
            sum = longint'(a8) + b8 + cin8;
            chk("rnd8_sum", {cout8, s8}, sum);
            chk("rnd8_ovf", ovf8, ovf_ref(a8, b8, cin8, 8));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
